// File: rtl/pipelined_multiply.sv
// Pipelined signed/unsigned multiplier with valid/ready flow control and a
// global stall enable. The optional round-half-up output stage is selected by PIPELINED_MULTIPLY_ROUND_EN.
module pipelined_multiply #(
  parameter int AWIDTH  = 16,
  parameter int BWIDTH  = 16,
  parameter int LATENCY = 3,
  parameter int SHIFT   = 0,
  localparam int OUTWID = AWIDTH + BWIDTH - SHIFT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [AWIDTH-1:0] i_a,
  input  logic [BWIDTH-1:0] i_b,
  input  logic              i_signed,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OUTWID-1:0] o_prod
);

  // Handshake: a transfer happens on any rising edge where valid && ready.
  // The whole pipe moves together under en, so o_ready is simply en.
  localparam int PW      = AWIDTH + BWIDTH;
  localparam int DEPTH   = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [PW-1:0] RND_ONE = PW'(1) << RND_POS;

  logic en;
  logic prod_valid;
  logic [OUTWID-1:0] prod_data;

  assign en      = i_ready || !o_valid;
  assign o_ready = en;

  // The true result always fits in PW bits, so the rounding add cannot
  // disturb the retained bits even though the carry out is not kept.
  function automatic logic [OUTWID-1:0] mul_shift(input logic [AWIDTH-1:0] a,
                                                  input logic [BWIDTH-1:0] b,
                                                  input logic sgn);
    logic [PW-1:0] ae;
    logic [PW-1:0] be;
    logic [PW-1:0] p;
    ae = sgn ? {{BWIDTH{a[AWIDTH-1]}}, a} : {{BWIDTH{1'b0}}, a};
    be = sgn ? {{AWIDTH{b[BWIDTH-1]}}, b} : {{AWIDTH{1'b0}}, b};
    p  = ae * be;
`ifdef PIPELINED_MULTIPLY_ROUND_EN
    if (SHIFT > 0) p = p + RND_ONE;
`endif
    return p[PW-1:SHIFT];
  endfunction

  if (LATENCY == 1) begin : g_direct
    assign prod_valid = i_valid;
    assign prod_data  = mul_shift(i_a, i_b, i_signed);
  end else begin : g_operand_stage
    logic              s1_valid_q, s1_valid_d;
    logic [AWIDTH-1:0] s1_a_q, s1_a_d;
    logic [BWIDTH-1:0] s1_b_q, s1_b_d;
    logic              s1_signed_q, s1_signed_d;

    always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_signed_d = s1_signed_q;
      if (en) begin
        s1_valid_d  = i_valid;
        s1_a_d      = i_a;
        s1_b_d      = i_b;
        s1_signed_d = i_signed;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        s1_valid_q  <= 1'b0;
        s1_a_q      <= '0;
        s1_b_q      <= '0;
        s1_signed_q <= 1'b0;
      end else begin
        s1_valid_q  <= s1_valid_d;
        s1_a_q      <= s1_a_d;
        s1_b_q      <= s1_b_d;
        s1_signed_q <= s1_signed_d;
      end
    end

    assign prod_valid = s1_valid_q;
    assign prod_data  = mul_shift(s1_a_q, s1_b_q, s1_signed_q);
  end

  logic [DEPTH-1:0]             pv_q, pv_d;
  logic [DEPTH-1:0][OUTWID-1:0] pd_q, pd_d;

  always_comb begin
    pv_d = pv_q;
    pd_d = pd_q;
    if (en) begin
      pv_d[0] = prod_valid;
      pd_d[0] = prod_data;
      for (int i = 1; i < DEPTH; i++) begin
        pv_d[i] = pv_q[i-1];
        pd_d[i] = pd_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pv_q <= '0;
      pd_q <= '0;
    end else begin
      pv_q <= pv_d;
      pd_q <= pd_d;
    end
  end

  assign o_valid = pv_q[DEPTH-1];
  assign o_prod  = pd_q[DEPTH-1];

endmodule
